// File: rtl/countdown_timer.sv
// Loadable, pausable down-counter with prescaler and one-cycle Done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from R at terminal count (periodic divider).
module countdown_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q, q_n;
    logic [WIDTH-1:0] r, r_n;
    logic [PCW-1:0]   pc, pc_n;
    logic             done, done_n;
    logic             tick;

    assign tick = En && (pc == PCW'(PRESCALE - 1));

    always_comb begin
        state_n = state;
        q_n     = q;
        r_n     = r;
        pc_n    = pc;
        done_n  = 1'b0;
        if (Load) begin
            q_n     = D;
            r_n     = D;
            pc_n    = '0;
            state_n = (D != '0) ? RUN : IDLE;
        end else begin
            unique case (state)
                RUN: begin
                    if (tick) begin
                        pc_n = '0;
                        if (q == WIDTH'(1)) begin
                            done_n = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            q_n     = r;
`else
                            q_n     = '0;
                            state_n = DONE;
`endif
                        end else begin
                            q_n = q - WIDTH'(1);
                        end
                    end else if (En) begin
                        pc_n = pc + PCW'(1);
                    end
                end
                IDLE, DONE: begin
                    state_n = state;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state <= IDLE;
            q     <= '0;
            r     <= '0;
            pc    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            r     <= r_n;
            pc    <= pc_n;
            done  <= done_n;
        end
    end

    assign Q    = q;
    assign Zero = (q == '0);
    assign Busy = (state == RUN);
    assign Done = done;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: two instances (PRESCALE 1 and 4)
// driven by shared stimulus, checked against an elapsed-cycle reference model.
module tb_countdown_timer;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             zero;
        logic             busy;
        logic             done;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Clr = 1'b0;
    logic             En = 1'b0;
    logic             Load = 1'b0;
    logic [WIDTH-1:0] D = '0;

    logic [WIDTH-1:0] q0, q1;
    logic             zero0, zero1, busy0, busy1, done0, done1;

    int checks = 0;
    int fails  = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    // Model state: loaded value, enabled cycles elapsed in the run, running flag
    int    mq[2];
    int    md[2];
    int    n[2];
    bit    run[2];
    bit    mdone[2];

    always #5 Clk = ~Clk;

    countdown_timer #(.WIDTH(WIDTH), .PRESCALE(1)) dut0 (
        .Clk(Clk), .Clr(Clr), .En(En), .Load(Load), .D(D),
        .Q(q0), .Zero(zero0), .Busy(busy0), .Done(done0)
    );

    countdown_timer #(.WIDTH(WIDTH), .PRESCALE(4)) dut1 (
        .Clk(Clk), .Clr(Clr), .En(En), .Load(Load), .D(D),
        .Q(q1), .Zero(zero1), .Busy(busy1), .Done(done1)
    );

    function automatic int pre(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic exp_t step(int i, bit clr, bit ld, bit en, int d);
        exp_t e;
        mdone[i] = 1'b0;
        if (clr) begin
            mq[i] = 0; md[i] = 0; n[i] = 0; run[i] = 1'b0;
        end else if (ld) begin
            md[i] = d; mq[i] = d; n[i] = 0; run[i] = (d != 0);
        end else if (run[i] && en) begin
            n[i]++;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            mq[i] = md[i] - ((n[i] / pre(i)) % md[i]);
            if (n[i] % (pre(i) * md[i]) == 0) mdone[i] = 1'b1;
`else
            mq[i] = md[i] - n[i] / pre(i);
            if (mq[i] == 0) begin
                mdone[i] = 1'b1;
                run[i]   = 1'b0;
            end
`endif
        end
        e.q    = WIDTH'(mq[i]);
        e.zero = (mq[i] == 0);
        e.busy = run[i];
        e.done = mdone[i];
        return e;
    endfunction

    task automatic cyc(bit clr, bit ld, bit en, int d);
        Clr  = clr;
        Load = ld;
        En   = en;
        D    = WIDTH'(d);
        @(posedge Clk);
        sb0.push_back(step(0, clr, ld, en, d));
        sb1.push_back(step(1, clr, ld, en, d));
        #1;
    endtask

    task automatic run_en(int cycles, bit en);
        for (int k = 0; k < cycles; k++) cyc(0, 0, en, 0);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            checks++;
            if (q0 !== e.q || zero0 !== e.zero || busy0 !== e.busy || done0 !== e.done) begin
                fails++;
                $display("FAIL p1 t=%0t got q=%0d z=%b b=%b d=%b want q=%0d z=%b b=%b d=%b",
                         $time, q0, zero0, busy0, done0, e.q, e.zero, e.busy, e.done);
            end
        end
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            checks++;
            if (q1 !== e.q || zero1 !== e.zero || busy1 !== e.busy || done1 !== e.done) begin
                fails++;
                $display("FAIL p4 t=%0t got q=%0d z=%b b=%b d=%b want q=%0d z=%b b=%b d=%b",
                         $time, q1, zero1, busy1, done1, e.q, e.zero, e.busy, e.done);
            end
        end
    end

    initial begin
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        run_en(10, 1);

        cyc(0, 1, 0, 5);
        run_en(8, 1);

        cyc(0, 1, 0, 6);
        run_en(3, 1);
        run_en(3, 0);
        run_en(6, 1);

        cyc(0, 1, 0, 5);
        run_en(3, 1);
        cyc(0, 1, 1, 9);
        run_en(2, 1);
        cyc(0, 1, 1, 0);
        run_en(3, 1);

        cyc(1, 1, 1, 7);
        run_en(2, 1);
        cyc(0, 1, 0, 1);
        cyc(1, 0, 1, 0);
        run_en(2, 1);

        cyc(0, 1, 0, 2);
        run_en(12, 1);

        cyc(0, 1, 0, 3);
        run_en(14, 1);

        cyc(0, 1, 0, 255);
        run_en(1100, 1);

        for (int k = 0; k < 4000; k++) begin
            bit clr, ld, en;
            int d;
            clr = ($urandom_range(0, 99) == 0);
            ld  = ($urandom_range(0, 39) == 0);
            en  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: d = 0;
                1: d = 255;
                default: d = $urandom_range(1, 12);
            endcase
            cyc(clr, ld, en, d);
        end

        @(negedge Clk);
        #1;
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d/%0d left want 0/0", sb0.size(), sb1.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
